fsmc_slave_axi_bridge: RTL
==========================

FSMC_SLAVE_AXI_BRIDGE -- requirements
Module: fsmc_slave_axi_bridge

Interface
REQ-001 The block SHALL have parameter simulation_delay, default 0: simulation-only register update delay in ns.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: AXI address that FSMC address 0 maps to.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2 (legal 2..4): synchronizer depth for the FSMC control pins.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous and active-high.
- fsmc_ne, fsmc_noe, fsmc_nwe  in  1 each  chip select, read strobe, write strobe; all active-low.
- fsmc_nbl  in  2  byte lane mask, active-low.
- fsmc_addr  in  26  half-word address.
- fsmc_data_i  in  16  data driven by the host.
- fsmc_data_o  out  16  read data driven back to the host.
- fsmc_data_t  out  16  tristate control; 1 = input, 0 = drive.
- m_axi_araddr  out  32  AXI-Lite master read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- m_axi_awaddr  out  32  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write byte strobes.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- err_pulse  out  1  one-cycle pulse on an AXI error response.
- overrun_pulse  out  1  one-cycle pulse when a strobe arrives while the block is busy.

Function
REQ-005 fsmc_ne, fsmc_noe and fsmc_nwe SHALL each pass through a SYNC_STAGES flip-flop synchronizer, reset to 1; all edge detection SHALL use the synchronized values.
REQ-006 A write event SHALL be a synchronized rising edge of nwe while synchronized ne is 0.
REQ-007 On a write event, fsmc_addr, fsmc_data_i and fsmc_nbl SHALL be captured raw on the same clk; the host holds them stable for the data-hold time.
REQ-008 A read event SHALL be a synchronized falling edge of noe while synchronized ne is 0; fsmc_addr SHALL be captured on that edge.
REQ-009 The AXI byte address SHALL be BASE_ADDR + {fsmc_addr, 1'b0}, computed modulo 2^32; wrap-around is permitted.
REQ-010 The AXI address SHALL be word-aligned, i.e. bits[1:0] forced to 0.
REQ-011 The FSM SHALL have states IDLE, RD_AR, RD_R, WR_AW_W, WR_B, with these transitions:
- IDLE->RD_AR on a read event.
- IDLE->WR_AW_W on a write event.
- RD_AR->RD_R on AR handshake.
- RD_R->IDLE on R handshake.
- WR_AW_W->WR_B once both AW and W have handshaken, in any order or together.
- WR_B->IDLE on B handshake.
REQ-012 If a read event and a write event occur in the same cycle, the write SHALL win and overrun_pulse SHALL fire.
REQ-013 The write lane SHALL be selected by fsmc_addr[0]:
- 0: m_axi_wdata = {16'h0, data} and m_axi_wstrb = {2'b00, ~nbl}.
- 1: m_axi_wdata = {data, 16'h0} and m_axi_wstrb = {~nbl, 2'b00}.
REQ-014 If nbl = 2'b11, the write SHALL still be issued, with all-zero strobes.
REQ-015 m_axi_rready SHALL be 1 only in RD_R, and m_axi_bready SHALL be 1 only in WR_B.
REQ-016 A valid signal SHALL stay high until its handshake completes; AW and W SHALL each deassert independently after their own handshake.
REQ-017 On R handshake, the half-word selected by the captured addr[0] SHALL be stored in a read-data register, and fsmc_data_o SHALL show that register.
REQ-018 fsmc_data_t SHALL be 16'h0000 while raw fsmc_ne = 0 and raw fsmc_noe = 0, and 16'hFFFF otherwise; this is combinational on the raw pins.
REQ-019 A read event or write event arriving while the state is not IDLE SHALL be dropped and SHALL pulse overrun_pulse for one cycle.
REQ-020 Read latency SHALL be SYNC_STAGES + 1 + AXI latency clocks from the noe fall to valid fsmc_data_o; the host's data_set time must cover this.

Reset
REQ-021 While rst = 1, the state SHALL be IDLE and all *valid, *ready, err_pulse and overrun_pulse outputs SHALL be 0.
REQ-022 While rst = 1, fsmc_data_o SHALL be 16'h0000, fsmc_data_t SHALL be 16'hFFFF, and synchronizer flops SHALL be 1.
REQ-023 Reset asserted mid-transaction SHALL abort it at once; no AXI valid SHALL remain asserted, and the first event after release starts cleanly.

Configuration
REQ-024 Macro FSMC_SLV_RESP_CHK_EN defined: a non-zero rresp or bresp SHALL pulse err_pulse for one cycle at the handshake.
REQ-025 Macro FSMC_SLV_RESP_CHK_EN defined: a non-zero rresp SHALL load 16'hFFFF into the read-data register instead of rdata.
REQ-026 Macro FSMC_SLV_RESP_CHK_EN undefined: responses SHALL be ignored and err_pulse SHALL be tied to 0.

Verification
REQ-027 Write addr 26'h10, data 16'hA55A, nbl 2'b00 -> awaddr 32'h20, wdata 32'h0000_A55A, wstrb 4'b0011; exactly one B handshake.
REQ-028 Write addr 26'h11, data 16'h1234, nbl 2'b10 -> awaddr 32'h20, wdata 32'h1234_0000, wstrb 4'b0100.
REQ-029 Read addr 26'h3 with rdata 32'hBEEF_CAFE -> araddr 32'h4; fsmc_data_o 16'hBEEF with fsmc_data_t 16'h0000 while noe is low.
REQ-030 AW and W ready skewed by 5 clocks, then a second nwe pulse sent during WR_B -> exactly one AXI write, and overrun_pulse pulses once.
REQ-031 Macro defined, read answered with rresp 2'b10 -> fsmc_data_o 16'hFFFF, err_pulse high for one cycle; macro undefined -> err_pulse stays 0.
REQ-032 rst asserted in RD_AR -> arvalid 0 the next clk; a post-reset read completes normally.

Source files
------------

// File: rtl/fsmc_slave_axi_bridge.sv
// ============================================================================
// fsmc_slave_axi_bridge
// ----------------------------------------------------------------------------
// Purpose:
//   Lets an FSMC host (asynchronous SRAM-style bus) reach an AXI-Lite slave
//   space. The FSMC strobes are synchronized into clk. A read or write strobe
//   edge starts one AXI-Lite transaction. Each transaction covers one 16-bit
//   half-word, placed in the correct lane of a 32-bit AXI word.
//
// Configuration macro:
//   FSMC_SLV_RESP_CHK_EN - when defined, a non-zero RRESP or BRESP pulses
//                          err_pulse. A failed read also returns 16'hFFFF to
//                          the host in place of the AXI data. When undefined,
//                          responses are ignored and err_pulse is tied to 0.
//
// Parameters:
//   simulation_delay - register update delay for simulation, in ns. It has
//                      no effect on the synthesized logic.
//   BASE_ADDR        - AXI byte address that FSMC half-word address 0 maps to.
//   SYNC_STAGES      - depth of the strobe synchronizers (2..4).
//
// Ports:
//   clk, rst                      - clock; asynchronous active-high reset
//   fsmc_ne/noe/nwe               - chip select / read / write strobes (active-low)
//   fsmc_nbl[1:0]                 - byte lane mask (active-low)
//   fsmc_addr[25:0]               - half-word address
//   fsmc_data_i/o/t[15:0]         - data in, read data out, tristate (1 = input)
//   m_axi_ar*/r*                  - AXI-Lite read address / read data channels
//   m_axi_aw*/w*/b*               - AXI-Lite write address / data / response
//   err_pulse                     - one-cycle pulse on an AXI error response
//   overrun_pulse                 - one-cycle pulse when a strobe event is dropped
// ============================================================================
module fsmc_slave_axi_bridge #(
    parameter int          simulation_delay = 0,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          SYNC_STAGES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fsmc_ne,
    input  logic        fsmc_noe,
    input  logic        fsmc_nwe,
    input  logic [1:0]  fsmc_nbl,
    input  logic [25:0] fsmc_addr,
    input  logic [15:0] fsmc_data_i,
    output logic [15:0] fsmc_data_o,
    output logic [15:0] fsmc_data_t,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        err_pulse,
    output logic        overrun_pulse
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_AR   = 3'd1,
        RD_R    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ne_sync;
    logic [SYNC_STAGES-1:0] r_noe_sync;
    logic [SYNC_STAGES-1:0] r_nwe_sync;
    logic                   r_noe_prev;
    logic                   r_nwe_prev;
    logic                   r_rd_lane;
    logic [15:0]            r_rdata;
    logic [31:0]            r_araddr;
    logic                   r_arvalid;
    logic                   r_rready;
    logic [31:0]            r_awaddr;
    logic                   r_awvalid;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_err;
    logic                   r_overrun;

    logic                   w_ne_s;
    logic                   w_noe_s;
    logic                   w_nwe_s;
    logic                   w_wr_ev;
    logic                   w_rd_ev;
    logic [31:0]            w_axi_addr;
    logic [31:0]            w_wdata;
    logic [3:0]             w_wstrb;
    logic [15:0]            w_rhalf;
    logic                   w_resp_err;
    logic                   w_aw_done;
    logic                   w_w_done;

    // The delay parameter only matters to simulation models; it is kept
    // visible here so that it is not reported as unused.
    logic [31:0]            w_unused_delay;
    assign w_unused_delay = 32'(simulation_delay);

    // Synchronizers for the strobe pins, plus the previous synchronized
    // strobe values used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ne_sync  <= {SYNC_STAGES{1'b1}};
            r_noe_sync <= {SYNC_STAGES{1'b1}};
            r_nwe_sync <= {SYNC_STAGES{1'b1}};
            r_noe_prev <= 1'b1;
            r_nwe_prev <= 1'b1;
        end else begin
            r_ne_sync  <= {r_ne_sync[SYNC_STAGES-2:0],  fsmc_ne};
            r_noe_sync <= {r_noe_sync[SYNC_STAGES-2:0], fsmc_noe};
            r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], fsmc_nwe};
            r_noe_prev <= w_noe_s;
            r_nwe_prev <= w_nwe_s;
        end
    end

    assign w_ne_s  = r_ne_sync[SYNC_STAGES-1];
    assign w_noe_s = r_noe_sync[SYNC_STAGES-1];
    assign w_nwe_s = r_nwe_sync[SYNC_STAGES-1];

    // A write completes on the rising nwe edge; a read starts on the falling noe edge.
    assign w_wr_ev = w_nwe_s & ~r_nwe_prev & ~w_ne_s;
    assign w_rd_ev = ~w_noe_s & r_noe_prev & ~w_ne_s;

    // The half-word address becomes a byte offset. Wrap-around past 2^32 is
    // allowed. The result is forced to word alignment.
    assign w_axi_addr = (BASE_ADDR + {5'b00000, fsmc_addr, 1'b0}) & 32'hFFFF_FFFC;

    // Place the raw write half-word and its byte enables in the lane chosen by addr[0].
    always_comb begin
        w_wdata = 32'h0000_0000;
        w_wstrb = 4'b0000;
        if (fsmc_addr[0]) begin
            w_wdata = {fsmc_data_i, 16'h0000};
            w_wstrb = {~fsmc_nbl, 2'b00};
        end else begin
            w_wdata = {16'h0000, fsmc_data_i};
            w_wstrb = {2'b00, ~fsmc_nbl};
        end
    end

    // Pick the returned half-word, and flag error responses when checking is enabled.
    always_comb begin
        w_rhalf    = 16'h0000;
        w_resp_err = 1'b0;
        if (r_rd_lane) begin
            w_rhalf = m_axi_rdata[31:16];
        end else begin
            w_rhalf = m_axi_rdata[15:0];
        end
`ifdef FSMC_SLV_RESP_CHK_EN
        if ((r_state == RD_R) && m_axi_rvalid && (m_axi_rresp != 2'b00)) begin
            w_rhalf    = 16'hFFFF;
            w_resp_err = 1'b1;
        end else if ((r_state == WR_B) && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
            w_resp_err = 1'b1;
        end else begin
            w_resp_err = 1'b0;
        end
`else
        w_resp_err = 1'b0;
`endif
    end

`ifndef FSMC_SLV_RESP_CHK_EN
    logic [3:0] w_unused_resp;
    assign w_unused_resp = {m_axi_rresp, m_axi_bresp};
`endif

    // A channel counts as done once its valid has dropped, or when it is
    // handshaking in this cycle.
    assign w_aw_done = ~r_awvalid | m_axi_awready;
    assign w_w_done  = ~r_wvalid  | m_axi_wready;

    // Transaction FSM. It drives every AXI handshake output, the read-data
    // register and the status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rd_lane <= 1'b0;
            r_rdata   <= 16'h0000;
            r_araddr  <= 32'h0000_0000;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= 32'h0000_0000;
            r_awvalid <= 1'b0;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'b0000;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_err     <= w_resp_err;
            // Events that cannot be served are dropped. When a read and a
            // write arrive together, the write is served and the read dropped.
            r_overrun <= ((w_rd_ev | w_wr_ev) & (r_state != IDLE)) |
                         (w_rd_ev & w_wr_ev & (r_state == IDLE));
            case (r_state)
                IDLE: begin
                    if (w_wr_ev) begin
                        r_awaddr  <= w_axi_addr;
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= WR_AW_W;
                    end else if (w_rd_ev) begin
                        r_araddr  <= w_axi_addr;
                        r_rd_lane <= fsmc_addr[0];
                        r_arvalid <= 1'b1;
                        r_state   <= RD_AR;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_R;
                    end else begin
                        r_state   <= RD_AR;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        r_rdata  <= w_rhalf;
                        r_rready <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_state  <= RD_R;
                    end
                end
                WR_AW_W: begin
                    if (r_awvalid && m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end else begin
                        r_awvalid <= r_awvalid;
                    end
                    if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end else begin
                        r_wvalid <= r_wvalid;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end else begin
                        r_state  <= WR_AW_W;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_state  <= WR_B;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign fsmc_data_o   = r_rdata;
    // The host may drive the bus unless it is reading; this follows the raw pins.
    assign fsmc_data_t   = (rst | fsmc_ne | fsmc_noe) ? 16'hFFFF : 16'h0000;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign err_pulse     = r_err;
    assign overrun_pulse = r_overrun;

endmodule
